display_scan_controller: RTL

Sequences the HUB75-style LED matrix scan around the per-pixel colour encoder. For each row pair it shifts one line of pixels out under a delayed shift clock and latches it. It then drives the panel row address and gates output-enable for one PWM subframe, stepping the encoder's compare `cycle` value through every threshold. It sits between the framebuffer read port (which it addresses) and the panel pins, and it compensates for the fixed pipeline latency of framebuffer plus encoder.

---
 rtl/display_scan_pkg.sv | 21 ++
 rtl/display_scan_delay.sv | 26 ++
 rtl/display_scan_controller.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/display_scan_pkg.sv
// Shared state encoding, guard length and PWM helper for the HUB75 scan controller.
package display_scan_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SHIFT,
      DRAIN,
      LATCH,
      GUARD,
      ON,
      ADVANCE
   } scan_state_t;

   localparam int unsigned GUARD_CYCLES = 4;

   // Largest compare value for a PWM counter of the given width.
   function automatic int unsigned max_cycle(input int unsigned width);
      return (32'd1 << width) - 32'd1;
   endfunction

endpackage

// File: rtl/display_scan_delay.sv
// Shift-register delay line with synchronous clear; re-times the shift strobe to the pixel pipeline.
module display_scan_delay #(
   parameter int unsigned stages = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic dout
);

   logic [stages-1:0] taps;

   always_ff @(posedge clk) begin
      if (rst) begin
         taps <= '0;
      end else begin
         taps[0] <= din;
         for (int unsigned i = 1; i < stages; i++) begin
            taps[i] <= taps[i-1];
         end
      end
   end

   assign dout = taps[stages-1];

endmodule

// File: rtl/display_scan_controller.sv
// HUB75 row/subframe scan sequencer with framebuffer + encoder latency compensation.
// Optional DISPLAY_SCAN_ROW_GUARD_EN adds a blanked GUARD state and a separate panel row register.
module display_scan_controller
   import display_scan_pkg::*;
#(
   parameter int unsigned columns    = 64,
   parameter int unsigned rowbits    = 4,
   parameter int unsigned cyclewidth = 8,
   parameter int unsigned latency    = 2,
   parameter int unsigned on_cycles  = 16
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        enable,
   output logic [$clog2(columns)-1:0]  col_addr,
   output logic [rowbits-1:0]          row_addr,
   output logic [cyclewidth-1:0]       cycle,
   output logic                        dclk,
   output logic                        lat,
   output logic                        oe_n,
   output logic                        busy,
   output logic                        frame_done
);

   localparam int unsigned COL_W = $clog2(columns);
   localparam logic [cyclewidth-1:0] CYCLE_MAX   = cyclewidth'(max_cycle(cyclewidth));
   localparam logic [cyclewidth-1:0] CYCLE_FIRST = cyclewidth'(1);
   localparam logic [31:0] SHIFT_LAST = 32'(2 * columns - 1);
   localparam logic [31:0] DRAIN_LAST = 32'(latency - 1);
   localparam logic [31:0] GUARD_LAST = 32'(GUARD_CYCLES - 1);
   localparam logic [31:0] ON_LAST    = 32'(on_cycles - 1);

   scan_state_t          state, state_n;
   logic [31:0]          cnt, cnt_n;
   logic [rowbits-1:0]   fetch_row, row_n;
   logic [cyclewidth-1:0] cycle_n;
   logic                 done_n;
   logic                 sclk_raw;

   always_comb begin
      state_n = state;
      cnt_n   = cnt + 32'd1;
      row_n   = fetch_row;
      cycle_n = cycle;
      done_n  = 1'b0;
      unique case (state)
         IDLE: begin
            cnt_n = '0;
            if (enable) state_n = SHIFT;
         end
         SHIFT: begin
            if (cnt == SHIFT_LAST) begin
               state_n = DRAIN;
               cnt_n   = '0;
            end
         end
         DRAIN: begin
            if (cnt == DRAIN_LAST) begin
               state_n = LATCH;
               cnt_n   = '0;
            end
         end
         LATCH: begin
            cnt_n = '0;
`ifdef DISPLAY_SCAN_ROW_GUARD_EN
            state_n = GUARD;
`else
            state_n = ON;
`endif
         end
         GUARD: begin
            if (cnt == GUARD_LAST) begin
               state_n = ON;
               cnt_n   = '0;
            end
         end
         ON: begin
            if (cnt == ON_LAST) begin
               state_n = ADVANCE;
               cnt_n   = '0;
            end
         end
         ADVANCE: begin
            cnt_n = '0;
            if (cycle == CYCLE_MAX) begin
               cycle_n = CYCLE_FIRST;
               row_n   = fetch_row + rowbits'(1);
               done_n  = (fetch_row == '1);
            end else begin
               cycle_n = cycle + CYCLE_FIRST;
            end
            if (enable) begin
               state_n = SHIFT;
            end else begin
               state_n = IDLE;
               row_n   = '0;
               cycle_n = CYCLE_FIRST;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // Panel-facing outputs are registered from next-state values so they align with the state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         cnt        <= '0;
         fetch_row  <= '0;
         cycle      <= CYCLE_FIRST;
         frame_done <= 1'b0;
         col_addr   <= '0;
         sclk_raw   <= 1'b0;
         lat        <= 1'b0;
         oe_n       <= 1'b1;
         busy       <= 1'b0;
      end else begin
         state      <= state_n;
         cnt        <= cnt_n;
         fetch_row  <= row_n;
         cycle      <= cycle_n;
         frame_done <= done_n;
         if (state_n == SHIFT) col_addr <= COL_W'(cnt_n >> 1);
         sclk_raw   <= (state_n == SHIFT) && cnt_n[0];
         lat        <= (state_n == LATCH);
         oe_n       <= (state_n != ON);
         busy       <= (state_n != IDLE);
      end
   end

   display_scan_delay #(
      .stages(latency)
   ) u_dclk_delay (
      .clk (clk),
      .rst (rst),
      .din (sclk_raw),
      .dout(dclk)
   );

`ifdef DISPLAY_SCAN_ROW_GUARD_EN
   logic [rowbits-1:0] panel_row;

   always_ff @(posedge clk) begin
      if (rst) begin
         panel_row <= '0;
      end else if (state == LATCH && state_n == GUARD) begin
         panel_row <= fetch_row;
      end else if (state_n == IDLE) begin
         panel_row <= '0;
      end
   end

   assign row_addr = panel_row;
`else
   assign row_addr = fetch_row;
`endif

endmodule
